// File: rtl/pseudo_ana_stick_n_if.sv
// Bundle of the per-frame request inputs and the analog-stick outputs of
// pseudo_ana_stick_n. The master side drives the joystick requests and the
// video position; the slave side (the stick emulator) returns the axis values.
interface pseudo_ana_stick_n_if #(
  parameter int W    = 8,
  parameter int AXES = 2
);
  logic [8:0]        pv_i;
  logic [AXES-1:0]   pos_i;
  logic [AXES-1:0]   neg_i;
  logic              hold_i;
  logic              recenter_i;
  logic [AXES*W-1:0] aout_o;
  logic [AXES-1:0]   active_o;
  logic              busy_o;

  modport master (
    output pv_i, pos_i, neg_i, hold_i, recenter_i,
    input  aout_o, active_o, busy_o
  );

  modport slave (
    input  pv_i, pos_i, neg_i, hold_i, recenter_i,
    output aout_o, active_o, busy_o
  );
endinterface

// File: rtl/pseudo_ana_stick_n.sv
// Multi-axis digital-to-analog stick emulator. Direction requests are
// snapshotted once per video frame and every axis is then walked one per
// clock through a single shared add/spring/clamp datapath. Axis values are
// kept signed around zero and presented offset-binary around 2^(W-1)-1.
// Optional feature macro: PSTK_ACCEL_EN (doubles the step after ACC_TICKS
// consecutive same-direction frames).
module pseudo_ana_stick_n #(
  parameter int W         = 8,
  parameter int AXES      = 2,
  parameter int STEP      = 15,
  parameter int LIMIT     = 120,
  parameter int ACC_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pseudo_ana_stick_n_if.slave  bus
);

  localparam int IDXW = (AXES > 1) ? $clog2(AXES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(AXES - 1);

  localparam logic signed [W+1:0] STP     = (W+2)'(STEP);
  localparam logic signed [W+1:0] NEG_STP = -STP;
  localparam logic signed [W+1:0] LIM     = (W+2)'(LIMIT);
  localparam logic signed [W+1:0] NEG_LIM = -LIM;
  localparam logic signed [W+1:0] CEN     = (W+2)'((2 ** (W - 1)) - 1);

  // Reject parameter sets whose clamped range cannot be encoded in W bits.
  if (LIMIT <= 0 || LIMIT > (2 ** (W - 1)) - 1 || STEP <= 0 || STEP > LIMIT || ACC_TICKS < 1)
  begin : gBadParams
    $error("pseudo_ana_stick_n: illegal W/STEP/LIMIT/ACC_TICKS combination");
  end

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [8:0]        pv_q;
  logic [AXES-1:0]   reqPos_q, reqNeg_q;
  logic              reqHold_q;
  logic signed [W+1:0] val_q [AXES];

  logic              tick;
  logic              start;
  logic              scanEn;
  logic [1:0]        dir;
  logic signed [W+1:0] curVal;
  logic signed [W+1:0] stepAmt;
  logic signed [W+1:0] sumVal;
  logic signed [W+1:0] val_d;

`ifdef PSTK_ACCEL_EN
  localparam int CW = $clog2(ACC_TICKS + 1);
  localparam logic [CW-1:0] ACC_SAT = CW'(ACC_TICKS);
  localparam logic signed [W+1:0] STP2 = (W+2)'(2 * STEP);

  logic [CW-1:0] cnt_q [AXES];
  logic [1:0]    prevDir_q [AXES];
  logic [CW-1:0] cnt_d;
`endif

  // A frame starts on the clock where the vertical counter wraps to zero.
  assign tick = (pv_q != bus.pv_i) && (bus.pv_i == 9'd0);

  // Sequencer next state: recentre wins, a stored or fresh tick starts a scan,
  // and a tick arriving mid-scan is parked in the one-deep pending flag.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    start     = 1'b0;
    scanEn    = 1'b0;
    if (bus.recenter_i) begin
      state_d   = IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick || pending_q) begin
            start     = 1'b1;
            state_d   = SCAN;
            idx_d     = '0;
            pending_d = 1'b0;
          end
        end
        SCAN: begin
          scanEn = 1'b1;
          if (tick) begin
            pending_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

  // Shared per-axis datapath: step toward the request, spring back without
  // overshooting zero when released, then clamp to the symmetric limit.
  always_comb begin
    curVal  = val_q[idx_q];
    dir     = {reqNeg_q[idx_q] & ~reqPos_q[idx_q], reqPos_q[idx_q] & ~reqNeg_q[idx_q]};
    stepAmt = STP;
`ifdef PSTK_ACCEL_EN
    cnt_d = '0;
    if (dir != 2'b00 && dir == prevDir_q[idx_q]) begin
      cnt_d = (cnt_q[idx_q] >= ACC_SAT) ? ACC_SAT : cnt_q[idx_q] + CW'(1);
    end
    if (cnt_d >= ACC_SAT) begin
      stepAmt = STP2;
    end
`endif
    case (dir)
      2'b01:   sumVal = curVal + stepAmt;
      2'b10:   sumVal = curVal - stepAmt;
      default: begin
        if (reqHold_q) begin
          sumVal = curVal;
        end else if (curVal <= STP && curVal >= NEG_STP) begin
          sumVal = '0;
        end else if (curVal > 0) begin
          sumVal = curVal - STP;
        end else begin
          sumVal = curVal + STP;
        end
      end
    endcase
    if (sumVal > LIM) begin
      val_d = LIM;
    end else if (sumVal < NEG_LIM) begin
      val_d = NEG_LIM;
    end else begin
      val_d = sumVal;
    end
  end

  // Frame detector history, request snapshot and per-axis value storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q      <= '0;
      reqPos_q  <= '0;
      reqNeg_q  <= '0;
      reqHold_q <= 1'b0;
      for (int k = 0; k < AXES; k++) begin
        val_q[k] <= '0;
`ifdef PSTK_ACCEL_EN
        cnt_q[k]     <= '0;
        prevDir_q[k] <= 2'b00;
`endif
      end
    end else begin
      pv_q <= bus.pv_i;
      if (start) begin
        reqPos_q  <= bus.pos_i;
        reqNeg_q  <= bus.neg_i;
        reqHold_q <= bus.hold_i;
      end
      if (bus.recenter_i) begin
        for (int k = 0; k < AXES; k++) begin
          val_q[k] <= '0;
`ifdef PSTK_ACCEL_EN
          cnt_q[k]     <= '0;
          prevDir_q[k] <= 2'b00;
`endif
        end
      end else if (scanEn) begin
        val_q[idx_q] <= val_d;
`ifdef PSTK_ACCEL_EN
        cnt_q[idx_q]     <= cnt_d;
        prevDir_q[idx_q] <= dir;
`endif
      end
    end
  end

  // Offset-binary presentation of each axis and its nonzero flag.
  for (genvar k = 0; k < AXES; k++) begin : gOut
    logic [W+1:0] outSum;
    assign outSum                 = val_q[k] + CEN;
    assign bus.aout_o[k*W +: W]   = outSum[W-1:0];
    assign bus.active_o[k]        = (val_q[k] != '0);
  end

  assign bus.busy_o = (state_q == SCAN);

endmodule
